// File: rtl/fpu_share_sched_pkg.sv
// Shared types for the FPU sharing scheduler: FPU operand/opcode types and
// the packed request record carried from the winning requester to the FPU.
package fpu_share_sched_pkg;

    typedef logic [15:0] floatType;

    typedef enum logic [0:0] {
        FPU_ADD  = 1'b0,
        FPU_MULT = 1'b1
    } FPU_opcode;

    typedef struct packed {
        FPU_opcode op;
        floatType  a;
        floatType  b;
    } fpu_req_t;

endpackage

// File: rtl/fpu_share_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible index found
// searching upward from rr_ptr, wrapping at N.
module fpu_share_sched_rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] rr_ptr,
    output logic [N-1:0] grant
);

    always_comb begin
        int  idx;
        logic found;
        // NOTE: every comb output gets a default before the search so no path leaves it unassigned (no latch).
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N) idx = idx - N;
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_share_sched.sv
// Shares one fixed-latency FPU among N_REQ requesters: round-robin issue,
// tag pipeline matched to the FPU latency, per-requester result registers.
module fpu_share_sched
    import fpu_share_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int FPU_LATENCY = 3,
    parameter int TAG_W       = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    input  FPU_opcode        req_op [N_REQ],
    input  floatType         req_a [N_REQ],
    input  floatType         req_b [N_REQ],
    output logic             fpu_in_valid,
    output FPU_opcode        fpu_op,
    output floatType         fpu_a,
    output floatType         fpu_b,
    input  logic             fpu_out_valid,
    input  floatType         fpu_result,
    output logic [N_REQ-1:0] res_valid,
    input  logic [N_REQ-1:0] res_ready,
    output floatType         res_data [N_REQ],
    output logic             busy,
    output logic             err
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } fpu_tag_t;

    localparam int BLANK_W = $clog2(FPU_LATENCY + 1);

    logic [N_REQ-1:0]   pending;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   drain;
    logic [N_REQ-1:0]   capture;
    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   winner;
    logic               transfer;
    fpu_req_t           issue_q;
    fpu_tag_t           ret_tag;
    logic [BLANK_W-1:0] blank_cnt;

    // Stage k holds the tag of the op issued k cycles ago; stage FPU_LATENCY lines up with the FPU result.
    fpu_tag_t tag_pipe [FPU_LATENCY+1];

    assign eligible = req_valid & ~pending;

    fpu_share_sched_rr_arbiter #(.N(N_REQ), .W(TAG_W)) u_arb (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .grant    (grant)
    );

    assign req_ready = grant;
    assign transfer  = |grant;
    assign busy      = |pending;
    assign drain     = res_valid & res_ready;
    assign ret_tag   = tag_pipe[FPU_LATENCY];
    assign fpu_op    = issue_q.op;
    assign fpu_a     = issue_q.a;
    assign fpu_b     = issue_q.b;

    always_comb begin
        winner = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant[i]) winner = TAG_W'(i);
    end

    always_comb begin
        capture = '0;
        if (fpu_out_valid && ret_tag.valid) capture[ret_tag.tag] = 1'b1;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            pending      <= '0;
            fpu_in_valid <= 1'b0;
            issue_q      <= '0;
        end else begin
            fpu_in_valid <= transfer;
            pending      <= (pending | grant) & ~drain;
            if (transfer) begin
                issue_q <= '{op: req_op[winner], a: req_a[winner], b: req_b[winner]};
                rr_ptr  <= (winner == TAG_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

    // NOTE: the tag pipeline and result array are reset too, so nothing in flight survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= FPU_LATENCY; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: transfer, tag: winner};
            for (int k = 1; k <= FPU_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= '0;
            for (int i = 0; i < N_REQ; i++) res_data[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (capture[i]) begin
                    res_data[i]  <= fpu_result;
                    res_valid[i] <= 1'b1;
                end else if (drain[i]) begin
                    res_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Results of ops issued before reset may still leave the FPU; ignore them for one latency window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_cnt <= BLANK_W'(FPU_LATENCY);
            err       <= 1'b0;
        end else if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - 1'b1;
        end else if (fpu_out_valid != ret_tag.valid) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fpu_share_sched.sv
// Directed bench for fpu_share_sched: single op, wrap, FPU mismatch, reset
// with ops in flight, continuous round-robin and result backpressure.
module tb_fpu_share_sched;
    import fpu_share_sched_pkg::*;

    localparam int N = 4;
    localparam int L = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [N-1:0] req_valid, req_ready, res_valid, res_ready;
    FPU_opcode  req_op [N];
    floatType   req_a [N];
    floatType   req_b [N];
    logic       fpu_in_valid, fpu_out_valid, busy, err;
    FPU_opcode  fpu_op;
    floatType   fpu_a, fpu_b, fpu_result;
    floatType   res_data [N];

    logic       stub_en, man_valid;
    floatType   man_res;
    logic [16:0] stub_pipe [L];

    int total, bad;
    int g0, g2, g3;

    logic [3:0] exp_rdy [12] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    logic [3:0] exp_rv  [12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001,
                                 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0001};

    always #5 clk = ~clk;

    // Stand-in FPU: fixed latency L, result = a ^ b.
    always @(posedge clk) begin
        stub_pipe[0] <= {fpu_in_valid, fpu_a ^ fpu_b};
        for (int k = 1; k < L; k++) stub_pipe[k] <= stub_pipe[k-1];
    end

    assign fpu_out_valid = stub_en ? stub_pipe[L-1][16]   : man_valid;
    assign fpu_result    = stub_en ? stub_pipe[L-1][15:0] : man_res;

    fpu_share_sched #(.N_REQ(N), .FPU_LATENCY(L)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .fpu_in_valid  (fpu_in_valid),
        .fpu_op        (fpu_op),
        .fpu_a         (fpu_a),
        .fpu_b         (fpu_b),
        .fpu_out_valid (fpu_out_valid),
        .fpu_result    (fpu_result),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .busy          (busy),
        .err           (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0; bad = 0; g0 = 0; g2 = 0; g3 = 0;
        stub_en = 1'b0; man_valid = 1'b0; man_res = '0;
        req_valid = '0; res_ready = '0;
        for (int i = 0; i < N; i++) begin
            req_op[i] = FPU_ADD; req_a[i] = '0; req_b[i] = '0;
        end

        // Asynchronous reset, checked before any clock edge.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_fpu_in_valid", fpu_in_valid, 1'b0);
        check("rst_res_valid", res_valid, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();

        // Single request from requester 2.
        req_valid = 4'b0100; req_op[2] = FPU_ADD; req_a[2] = 16'h0401; req_b[2] = 16'h0802;
        #1;
        check("single_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        #1;
        check("single_issue_valid", fpu_in_valid, 1'b1);
        check("single_issue_op", fpu_op, FPU_ADD);
        check("single_issue_a", fpu_a, 16'h0401);
        check("single_issue_b", fpu_b, 16'h0802);
        check("single_busy", busy, 1'b1);
        tick();
        check("single_issue_drop", fpu_in_valid, 1'b0);
        tick(); tick();
        man_valid = 1'b1; man_res = 16'h0C03;
        tick();
        man_valid = 1'b0;
        #1;
        check("single_res_valid", res_valid, 4'b0100);
        check("single_res_data", res_data[2], 16'h0C03);
        check("single_err", err, 1'b0);
        res_ready = 4'b0100;
        tick();
        res_ready = '0;
        #1;
        check("single_drained", res_valid, 4'b0000);
        check("single_busy_drop", busy, 1'b0);
        check("single_data_hold", res_data[2], 16'h0C03);

        // Wrap: rr_ptr is 3, requests from 0 and 3.
        stub_en = 1'b1; res_ready = 4'b1111;
        req_op[0] = FPU_MULT; req_a[0] = 16'h1111; req_b[0] = 16'h2222;
        req_op[3] = FPU_ADD;  req_a[3] = 16'h00F0; req_b[3] = 16'h0F00;
        req_valid = 4'b1001;
        #1;
        check("wrap_first", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0001;
        #1;
        check("wrap_second", req_ready, 4'b0001);
        check("wrap_issue3_a", fpu_a, 16'h00F0);
        check("wrap_issue3_op", fpu_op, FPU_ADD);
        tick();
        req_valid = '0;
        #1;
        check("wrap_issue0_a", fpu_a, 16'h1111);
        check("wrap_issue0_op", fpu_op, FPU_MULT);
        tick(); tick(); tick();
        check("wrap_res3_valid", res_valid, 4'b1000);
        tick();
        check("wrap_res0_valid", res_valid, 4'b0001);
        check("wrap_res3_data", res_data[3], 16'h0FF0);
        tick();
        check("wrap_idle", busy, 1'b0);
        check("wrap_res0_data", res_data[0], 16'h3333);
        req_valid = 4'b0011;
        #1;
        check("wrap_rr_ptr_1", req_ready, 4'b0010);
        req_valid = '0;
        #1;

        // FPU strobe with an empty tag pipeline.
        stub_en = 1'b0; man_valid = 1'b1; man_res = 16'hDEAD;
        tick();
        man_valid = 1'b0;
        #1;
        check("mismatch_err", err, 1'b1);
        check("mismatch_no_res", res_valid, 4'b0000);
        tick(); tick();
        check("mismatch_sticky", err, 1'b1);

        // Reset with two ops in flight.
        stub_en = 1'b1;
        req_valid = 4'b0011;
        #1;
        check("inflight_grant1", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0001;
        #1;
        check("inflight_grant0", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("rst2_fpu_in_valid", fpu_in_valid, 1'b0);
        check("rst2_fpu_a", fpu_a, 16'h0000);
        check("rst2_busy", busy, 1'b0);
        check("rst2_err", err, 1'b0);
        check("rst2_res_valid", res_valid, 4'b0000);
        check("rst2_res_data", res_data[3], 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        check("late_pulse_err", err, 1'b0);
        tick();
        check("late_pulse_err2", err, 1'b0);
        check("late_pulse_res", res_valid, 4'b0000);

        // All four requesting continuously with results drained at once.
        for (int i = 0; i < N; i++) begin
            req_op[i] = FPU_ADD;
            req_a[i]  = {4'(i + 1), 12'hA50};
            req_b[i]  = 16'(i + 1);
        end
        req_valid = 4'b1111;
        res_ready = 4'b1111;
        #1;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("rr_ready_%0d", k), req_ready, exp_rdy[k]);
            check($sformatf("rr_res_valid_%0d", k), res_valid, exp_rv[k]);
            tick();
        end
        req_valid = '0;
        #1;
        check("rr_data0", res_data[0], 16'h1A51);
        check("rr_data1", res_data[1], 16'h2A52);
        check("rr_data2", res_data[2], 16'h3A53);
        check("rr_data3", res_data[3], 16'h4A54);
        repeat (8) tick();
        check("rr_idle", busy, 1'b0);

        // Backpressure: requester 1 never drains its result.
        req_a[1] = 16'hABCD; req_b[1] = 16'h1234;
        res_ready = 4'b1101;
        req_valid = 4'b1111;
        #1;
        check("bp_grant0", req_ready, 4'b0001);
        tick();
        check("bp_grant1", req_ready, 4'b0010);
        tick();
        for (int k = 0; k < 14; k++) begin
            check($sformatf("bp_ready1_%0d", k), req_ready[1], 1'b0);
            if (k >= 4) check($sformatf("bp_data1_%0d", k), res_data[1], 16'hB9F9);
            g0 += int'(req_ready[0]);
            g2 += int'(req_ready[2]);
            g3 += int'(req_ready[3]);
            tick();
        end
        check("bp_grants0", g0, 2);
        check("bp_grants2", g2, 3);
        check("bp_grants3", g3, 3);
        check("bp_res1_held", res_valid[1], 1'b1);
        res_ready = 4'b1111;
        req_valid = '0;
        repeat (10) tick();
        check("bp_idle", busy, 1'b0);
        check("bp_err", err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
